// File: rtl/mips_pipe_pkg.sv
// Shared widths, control-bundle bit positions and opcodes for the 5-stage MIPS pipeline.
package mips_pipe_pkg;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  localparam int EX_REGDST   = 0;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUSRC   = 3;
  localparam int M_BRANCH    = 0;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 2;
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination is a source of the instruction in ID.
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic                  haz
);

  // $0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign haz = ex_valid & ex_memread & (ex_rt != '0) & id_valid &
               ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall/bubble and branch flush.
// Optional macro ID_EX_STALL_CNT_EN adds a 32-bit bubble counter on stall_cnt_o.
module id_ex_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WB_W-1:0]       wb_i,
  input  logic [M_W-1:0]        m_i,
  input  logic [EX_W-1:0]       ex_i,
  input  logic                  id_valid_i,
  input  logic                  flush_i,
  input  logic [DATA_W-1:0]     pc4_i,
  input  logic [DATA_W-1:0]     rd1_i,
  input  logic [DATA_W-1:0]     rd2_i,
  input  logic [DATA_W-1:0]     imm_i,
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [REG_ADDR_W-1:0] rt_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  output logic [WB_W-1:0]       wb_o,
  output logic [M_W-1:0]        m_o,
  output logic [EX_W-1:0]       ex_o,
  output logic                  valid_o,
  output logic [DATA_W-1:0]     pc4_o,
  output logic [DATA_W-1:0]     rd1_o,
  output logic [DATA_W-1:0]     rd2_o,
  output logic [DATA_W-1:0]     imm_o,
  output logic [REG_ADDR_W-1:0] rs_o,
  output logic [REG_ADDR_W-1:0] rt_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
`ifdef ID_EX_STALL_CNT_EN
  output logic [31:0]           stall_cnt_o,
`endif
  output logic                  bubble_o
);

  logic haz;
  logic stall;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard_detect (
    .ex_valid  (valid_o),
    .ex_memread(m_o[M_MEMREAD]),
    .ex_rt     (rt_o),
    .id_valid  (id_valid_i),
    .id_rs     (rs_i),
    .id_rt     (rt_i),
    .haz       (haz)
  );

  // valid_o qualifies the EX slot: when 0 the control bundles are clean zeros and the
  // slot is a bubble. A flush overrides a stall: the squashed instruction must not hold IF/ID.
  assign stall        = haz & ~flush_i;
  assign bubble_o     = stall;
  assign pc_write_o   = ~stall;
  assign ifid_write_o = ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_o    <= '0;
      m_o     <= '0;
      ex_o    <= '0;
      valid_o <= 1'b0;
      pc4_o   <= '0;
      rd1_o   <= '0;
      rd2_o   <= '0;
      imm_o   <= '0;
      rs_o    <= '0;
      rt_o    <= '0;
      rd_o    <= '0;
    end else begin
      pc4_o <= pc4_i;
      rd1_o <= rd1_i;
      rd2_o <= rd2_i;
      imm_o <= imm_i;
      rs_o  <= rs_i;
      rt_o  <= rt_i;
      rd_o  <= rd_i;
      if (flush_i || haz) begin
        wb_o    <= '0;
        m_o     <= '0;
        ex_o    <= '0;
        valid_o <= 1'b0;
      end else begin
        wb_o    <= id_valid_i ? wb_i : '0;
        m_o     <= id_valid_i ? m_i  : '0;
        ex_o    <= id_valid_i ? ex_i : '0;
        valid_o <= id_valid_i;
      end
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`endif

endmodule
